// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, decimal saturation limit and the
// multiplier sequencer states.
package alu_pkg;

   localparam int WIDTH   = 11;
   localparam int SAT_MAX = 999;
   localparam int CNT_W   = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SAT  = 2'd2
   } state_t;

endpackage

// File: rtl/sat_clamp.sv
// Clamps an unsigned product magnitude to SAT_MAX and applies the sign.
// A zero magnitude stays +0 whatever the sign.
module sat_clamp
   import alu_pkg::*;
#(
   parameter int WIDTH   = alu_pkg::WIDTH,
   parameter int SAT_MAX = alu_pkg::SAT_MAX
) (
   input  logic [2*WIDTH-1:0] mag_i,
   input  logic               neg_i,
   output logic [WIDTH-1:0]   res_o
);

   localparam logic [2*WIDTH-1:0] SAT_WIDE = (2*WIDTH)'(SAT_MAX);
   localparam logic [WIDTH-1:0]   SAT_NARR = WIDTH'(SAT_MAX);

   logic [WIDTH-1:0] clip_s;

   // Clamp the magnitude, then negate when the result sign is negative.
   always_comb begin
      clip_s = mag_i[WIDTH-1:0];
      res_o  = '0;
      if (mag_i > SAT_WIDE) begin
         clip_s = SAT_NARR;
      end else begin
         clip_s = mag_i[WIDTH-1:0];
      end
      if (neg_i) begin
         res_o = ~clip_s + WIDTH'(1);
      end else begin
         res_o = clip_s;
      end
   end

endmodule

// File: rtl/mul_unit.sv
// Sequential signed multiplier: shift-add over WIDTH cycles on operand
// magnitudes, then one saturation cycle that writes out and pulses done.
module mul_unit
   import alu_pkg::*;
#(
   parameter int WIDTH   = alu_pkg::WIDTH,
   parameter int SAT_MAX = alu_pkg::SAT_MAX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] arg1,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q,  mplr_d;
   logic [2*WIDTH-1:0]   prod_q,  prod_d;
   logic [CW-1:0]        cnt_q,   cnt_d;
   logic                 sign_q,  sign_d;
   logic [WIDTH-1:0]     out_q,   out_d;
   logic                 done_q,  done_d;
   logic [WIDTH-1:0]     sat_s;

   // -1024 maps to 1024: the unsigned reading of its own two's complement.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
   endfunction

   sat_clamp #(
      .WIDTH   (WIDTH),
      .SAT_MAX (SAT_MAX)
   ) u_sat_clamp (
      .mag_i (prod_q),
      .neg_i (sign_q),
      .res_o (sat_s)
   );

   // Next-state and datapath updates for the IDLE/CALC/SAT sequencer.
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = {{WIDTH{1'b0}}, mag(acc)};
               mplr_d  = mag(arg1);
               prod_d  = '0;
               cnt_d   = '0;
               sign_d  = acc[WIDTH-1] ^ arg1[WIDTH-1];
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (mplr_q[0]) begin
               prod_d = prod_q + mcand_q;
            end else begin
               prod_d = prod_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = SAT;
            end else begin
               state_d = CALC;
            end
         end
         SAT: begin
            out_d   = sat_s;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any multiply in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= '0;
         mplr_q  <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign out  = out_q;
   assign done = done_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: stimulus pushes expected products, a monitor
// pops and compares on every done pulse.
module tb_mul_unit;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic signed [10:0] acc = '0;
   logic signed [10:0] arg1 = '0;
   logic signed [10:0] out;
   logic               busy;
   logic               done;

   int n_tests = 0;
   int n_fail  = 0;
   logic signed [10:0] exp_q[$];

   mul_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .acc   (acc),
      .arg1  (arg1),
      .out   (out),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   initial begin
      logic signed [10:0] exp_v;
      forever begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done with out=%0d, expected no done", out);
            end else begin
               exp_v = exp_q.pop_front();
               check("product", int'(out), int'(exp_v));
            end
         end
      end
   end

   task automatic wait_idle();
      int guard = 0;
      while (busy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (busy) check("idle_timeout", 1, 0);
   endtask

   // Issue one start pulse; operands are scrambled right after acceptance.
   task automatic run_mul(input logic signed [10:0] a, input logic signed [10:0] b,
                          input logic signed [10:0] expv, input bit push);
      wait_idle();
      acc   = a;
      arg1  = b;
      start = 1'b1;
      if (push) exp_q.push_back(expv);
      @(negedge clk);
      start = 1'b0;
      acc   = 11'($urandom);
      arg1  = 11'($urandom);
   endtask

   initial begin
      int guard;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out", int'(out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic, mixed-sign, saturation and boundary vectors
      run_mul(11'sd3,     11'sd7,     11'sd21,   1'b1);
      run_mul(-11'sd5,    -11'sd17,   11'sd85,   1'b1);
      run_mul(-11'sd2,    11'sd421,   -11'sd842, 1'b1);
      run_mul(11'sd136,   11'sd492,   11'sd999,  1'b1);
      run_mul(11'sd844,   -11'sd91,   -11'sd999, 1'b1);
      run_mul(-11'sd1024, -11'sd1024, 11'sd999,  1'b1);
      run_mul(11'sd37,    11'sd27,    11'sd999,  1'b1);
      run_mul(11'sd40,    11'sd25,    11'sd999,  1'b1);
      run_mul(-11'sd1,    11'sd998,   -11'sd998, 1'b1);
      run_mul(-11'sd1024, 11'sd1,     -11'sd999, 1'b1);
      run_mul(-11'sd1024, 11'sd0,     11'sd0,    1'b1);
      run_mul(11'sd0,     -11'sd5,    11'sd0,    1'b1);

      // Handshake timing: busy after edges 0..11, done only after edge 12
      wait_idle();
      acc = 11'sd12; arg1 = -11'sd11; start = 1'b1;
      exp_q.push_back(-11'sd132);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_edge0", int'(busy), 1);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (k < 12) begin
            check("busy_calc", int'(busy), 1);
            check("done_early", int'(done), 0);
         end else begin
            check("busy_after_sat", int'(busy), 0);
            check("done_pulse", int'(done), 1);
         end
      end
      @(posedge clk);
      #1;
      check("done_one_cycle", int'(done), 0);

      // Start while busy must be ignored (monitor flags any extra done)
      @(negedge clk);
      run_mul(11'sd9, 11'sd11, 11'sd99, 1'b1);
      repeat (3) @(negedge clk);
      acc = 11'sd100; arg1 = 11'sd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (16) @(negedge clk);
      check("ignored_start_busy", int'(busy), 0);

      // Reset at edge 5 of a multiply aborts with no done
      run_mul(11'sd3, 11'sd7, 11'sd21, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out", int'(out), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (16) @(negedge clk);
      check("abort_no_restart", int'(busy), 0);
      run_mul(11'sd3, 11'sd7, 11'sd21, 1'b1);

      // Drain the scoreboard
      guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("drain_pending", exp_q.size(), 0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
